// File: rtl/dbg_cmd_uart_tx_if.sv
// Command/data/serial signal bundle for dbg_cmd_uart_tx.
// master = host side that issues descriptors; slave = the frame transmitter.
interface dbg_cmd_uart_tx_if;
    logic        cmd_valid_i;
    logic        cmd_accept_o;
    logic        cmd_read_i;
    logic [7:0]  cmd_len_i;
    logic [31:0] cmd_addr_i;
    logic        wr_data_valid_i;
    logic [7:0]  wr_data_i;
    logic        wr_data_accept_o;
    logic        txd_o;
    logic        busy_o;
    logic        done_o;

    modport master (
        output cmd_valid_i, cmd_read_i, cmd_len_i, cmd_addr_i,
        output wr_data_valid_i, wr_data_i,
        input  cmd_accept_o, wr_data_accept_o, txd_o, busy_o, done_o
    );

    modport slave (
        input  cmd_valid_i, cmd_read_i, cmd_len_i, cmd_addr_i,
        input  wr_data_valid_i, wr_data_i,
        output cmd_accept_o, wr_data_accept_o, txd_o, busy_o, done_o
    );
endinterface

// File: rtl/dbg_cmd_uart_tx.sv
// UART debug-bridge command initiator: serializes [CMD][LEN][ADDR x4][DATA..] as 8N1.
// Define DBG_CMD_UART_TX_TWO_STOP_EN to append a second stop bit to every byte.
module dbg_cmd_uart_tx #(
    parameter int          CLK_FREQ     = 100000000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter logic [7:0]  CMD_WRITE    = 8'h10,
    parameter logic [7:0]  CMD_READ     = 8'h11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dbg_cmd_uart_tx_if.slave bus
);
`ifdef DBG_CMD_UART_TX_TWO_STOP_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int SHIFT_W = NBITS - 1;
    localparam int CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BITS_AFTER0 = 4'(NBITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_LEN, S_ADDR, S_DATA, S_DRAIN, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic               rd_q, rd_d;
    logic [7:0]         len_q, len_d;
    logic [31:0]        addr_q, addr_d;
    logic [1:0]         addr_idx_q, addr_idx_d;
    logic [7:0]         rem_q, rem_d;
    logic               ser_busy_q, ser_busy_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [3:0]         bits_left_q, bits_left_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic               txd_q, txd_d;

    logic               ser_ready;
    logic               ld_valid;
    logic               ser_load;
    logic [7:0]         ld_byte;
    logic               cmd_accept;
    logic               wr_accept;

    // Ready on the final cycle of the last bit so the next start bit follows with no gap.
    assign ser_ready = !ser_busy_q ||
                       ((clk_cnt_q == CNT_LAST) && (bits_left_q == 4'd0));
    assign ser_load  = ld_valid && ser_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            len_q       <= '0;
            addr_q      <= '0;
            addr_idx_q  <= '0;
            rem_q       <= '0;
            ser_busy_q  <= 1'b0;
            shift_q     <= '0;
            bits_left_q <= '0;
            clk_cnt_q   <= '0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            addr_idx_q  <= addr_idx_d;
            rem_q       <= rem_d;
            ser_busy_q  <= ser_busy_d;
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
            clk_cnt_q   <= clk_cnt_d;
            txd_q       <= txd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        len_d      = len_q;
        addr_d     = addr_q;
        addr_idx_d = addr_idx_q;
        rem_d      = rem_q;
        ld_valid   = 1'b0;
        ld_byte    = 8'h00;
        cmd_accept = 1'b0;
        wr_accept  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_accept = 1'b1;
                if (bus.cmd_valid_i) begin
                    rd_d    = bus.cmd_read_i;
                    len_d   = bus.cmd_len_i;
                    addr_d  = bus.cmd_addr_i;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                ld_valid = 1'b1;
                ld_byte  = rd_q ? CMD_READ : CMD_WRITE;
                if (ser_ready) state_d = S_LEN;
            end
            S_LEN: begin
                ld_valid = 1'b1;
                ld_byte  = len_q;
                if (ser_ready) begin
                    addr_idx_d = 2'd3;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR: begin
                ld_valid = 1'b1;
                ld_byte  = addr_q[{addr_idx_q, 3'b000} +: 8];
                if (ser_ready) begin
                    if (addr_idx_q != 2'd0) begin
                        addr_idx_d = addr_idx_q - 2'd1;
                    end else if (!rd_q && (len_q != 8'd0)) begin
                        rem_d   = len_q;
                        state_d = S_DATA;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DATA: begin
                // A missing data byte simply leaves the line idle-high until it shows up.
                ld_valid  = bus.wr_data_valid_i;
                ld_byte   = bus.wr_data_i;
                wr_accept = ser_ready && bus.wr_data_valid_i;
                if (wr_accept) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (ser_ready) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ser_busy_d  = ser_busy_q;
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        clk_cnt_d   = clk_cnt_q;
        txd_d       = txd_q;
        if (ser_load) begin
            ser_busy_d  = 1'b1;
            txd_d       = 1'b0;
            shift_d     = {{(SHIFT_W-8){1'b1}}, ld_byte};
            bits_left_d = BITS_AFTER0;
            clk_cnt_d   = '0;
        end else if (ser_busy_q) begin
            if (clk_cnt_q == CNT_LAST) begin
                clk_cnt_d = '0;
                if (bits_left_q == 4'd0) begin
                    ser_busy_d = 1'b0;
                    txd_d      = 1'b1;
                end else begin
                    txd_d       = shift_q[0];
                    shift_d     = {1'b1, shift_q[SHIFT_W-1:1]};
                    bits_left_d = bits_left_q - 4'd1;
                end
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
    end

    // Accept is gated by reset so it reads 0 while reset is held, even though the FSM sits in IDLE.
    assign bus.cmd_accept_o     = cmd_accept && !rst_i;
    assign bus.wr_data_accept_o = wr_accept;
    assign bus.txd_o            = txd_q;
    assign bus.busy_o           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done_o           = (state_q == S_DONE);
endmodule

// File: tb/tb_dbg_cmd_uart_tx.sv
// Bench for dbg_cmd_uart_tx: UART decoding monitor, frame-level timing model, directed tests.
`timescale 1ns/1ps
module tb_dbg_cmd_uart_tx;
    localparam int CPB = 16;
`ifdef DBG_CMD_UART_TX_TWO_STOP_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int BYTE_CYC = NB * CPB;

    logic clk = 1'b0;
    logic rst;
    initial forever #5 clk = ~clk;

    dbg_cmd_uart_tx_if bus();
    dbg_cmd_uart_tx #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int start_q[$];
    int done_q[$];
    logic [7:0] data_arr[16];
    bit feed_en = 0;
    bit stall = 0;
    int feed_len = 0;
    bit timed = 1;
    int model_k = -1;
    int model_n = 0;
    int model_d = 0;
    bit model_rd = 0;

    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // UART receiver: captures every cycle of a byte, decodes at bit centres.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && bus.txd_o === 1'b0) begin
                logic samp [0:BYTE_CYC-1];
                logic [7:0] dec;
                logic [7:0] want;
                int st;
                int bad;
                bit abort;
                bit frame_ok;
                st = cyc;
                abort = 0;
                samp[0] = bus.txd_o;
                for (int i = 1; i < BYTE_CYC; i++) begin
                    @(negedge clk);
                    if (rst) begin abort = 1; break; end
                    samp[i] = bus.txd_o;
                end
                if (!abort) begin
                    bad = 0;
                    for (int i = 0; i < BYTE_CYC; i++)
                        if (samp[i] !== samp[(i / CPB) * CPB + CPB / 2]) bad++;
                    for (int b = 0; b < 8; b++) dec[b] = samp[(b + 1) * CPB + CPB / 2];
                    frame_ok = (samp[CPB / 2] === 1'b0);
                    for (int s = 9; s < NB; s++)
                        if (samp[s * CPB + CPB / 2] !== 1'b1) frame_ok = 0;
                    got_q.push_back(dec);
                    start_q.push_back(st);
                    check("byte_shape", {bad[31:0], 31'd0, frame_ok}, {32'd0, 31'd0, 1'b1});
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL byte_unexpected: got %0h, required no byte (cycle %0d)", dec, cyc);
                    end else begin
                        want = exp_q.pop_front();
                        check("byte_value", dec, want);
                    end
                end
            end
        end
    end

    // Frame-level model: a frame of N bytes starts 2 cycles after the handshake and
    // ends with done_o N*BYTE_CYC cycles after its first start bit.
    initial begin : compare
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                model_k = -1;
                exp_q.delete();
            end else begin
                if (bus.done_o) done_q.push_back(cyc);
                if (timed) begin
                    bit in_f;
                    bit ew;
                    in_f = (model_k >= 0) && (cyc >= model_k + 1) && (cyc <= model_d);
                    ew = 0;
                    if (model_k >= 0 && !model_rd)
                        for (int m = 6; m < model_n; m++)
                            if (cyc == model_k + 2 + m * BYTE_CYC - 1) ew = 1;
                    check("busy_o", bus.busy_o, in_f && (cyc != model_d));
                    check("done_o", bus.done_o, (model_k >= 0) && (cyc == model_d));
                    check("cmd_accept_o", bus.cmd_accept_o, !in_f);
                    check("wr_data_accept_o", bus.wr_data_accept_o, ew);
                end else begin
                    check("wr_accept_without_valid", bus.wr_data_accept_o & ~bus.wr_data_valid_i, 0);
                end
                if (bus.cmd_valid_i && bus.cmd_accept_o) begin
                    model_k  = cyc;
                    model_rd = bus.cmd_read_i;
                    model_n  = 6 + (bus.cmd_read_i ? 0 : int'(bus.cmd_len_i));
                    model_d  = cyc + 2 + model_n * BYTE_CYC;
                    exp_q.push_back(bus.cmd_read_i ? 8'h11 : 8'h10);
                    exp_q.push_back(bus.cmd_len_i);
                    for (int b = 3; b >= 0; b--) exp_q.push_back(bus.cmd_addr_i[b * 8 +: 8]);
                    if (!bus.cmd_read_i)
                        for (int j = 0; j < int'(bus.cmd_len_i); j++) exp_q.push_back(data_arr[j % 16]);
                end
            end
        end
    end

    initial begin : feeder
        int idx;
        bit took;
        idx = 0;
        took = 0;
        bus.wr_data_valid_i = 1'b0;
        bus.wr_data_i = 8'h00;
        forever begin
            @(negedge clk);
            if (!feed_en) idx = 0;
            else if (took) idx++;
            bus.wr_data_valid_i = feed_en && !stall && (idx < feed_len);
            bus.wr_data_i = data_arr[idx % 16];
            #1 took = bus.wr_data_valid_i && bus.wr_data_accept_o && !rst;
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic send_cmd(input bit rd, input logic [7:0] len, input logic [31:0] addr, output int xc);
        int n;
        @(negedge clk);
        bus.cmd_read_i = rd;
        bus.cmd_len_i = len;
        bus.cmd_addr_i = addr;
        bus.cmd_valid_i = 1'b1;
        #1;
        n = 0;
        while (!bus.cmd_accept_o && n < 20000) begin @(negedge clk); #1; n++; end
        xc = cyc;
        if (!bus.cmd_accept_o) begin
            n_chk++;
            $display("FAIL cmd_handshake: accept not seen in 20000 cycles, required a transfer");
        end
        @(posedge clk);
        #1 bus.cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        int n;
        n = 0;
        dc = -1;
        while (n < 20000) begin
            @(negedge clk);
            #3;
            if (bus.done_o) begin dc = cyc; break; end
            n++;
        end
        if (dc < 0) begin
            n_chk++;
            $display("FAIL done_timeout: done_o not seen in 20000 cycles, required a pulse");
        end
    endtask

    task automatic cmp_frame(input string name, input logic [7:0] want[$]);
        int mism;
        check({name, "_count"}, got_q.size(), want.size());
        mism = 0;
        foreach (want[i]) if (i >= got_q.size() || got_q[i] !== want[i]) mism++;
        check({name, "_bytes"}, mism, 0);
    endtask

    initial begin : stim
        logic [7:0] lit[$];
        int xc, x2, dc, d1, nd, bad, target, first;
        rst = 1'b1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_read_i = 1'b0;
        bus.cmd_len_i = 8'h00;
        bus.cmd_addr_i = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd", bus.txd_o, 1);
        check("rst_cmd_accept", bus.cmd_accept_o, 0);
        check("rst_wr_accept", bus.wr_data_accept_o, 0);
        check("rst_busy", bus.busy_o, 0);
        check("rst_done", bus.done_o, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write of 8 bytes, data always valid.
        lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        foreach (lit[i]) data_arr[i] = lit[i];
        feed_len = 8;
        feed_en = 1;
        got_q.delete();
        start_q.delete();
        send_cmd(0, 8'd8, 32'h0000_1000, xc);
        wait_done(dc);
        lit = '{8'h10, 8'h08, 8'h00, 8'h00, 8'h10, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        cmp_frame("wr_frame", lit);
        first = (start_q.size() > 0) ? start_q[0] : -1;
        check("wr_first_start", first, xc + 2);
`ifdef DBG_CMD_UART_TX_TWO_STOP_EN
        check("wr_duration", dc - first, 2464);
`else
        check("wr_duration", dc - first, 2240);
`endif
        bad = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != BYTE_CYC) bad++;
        check("wr_byte_spacing", bad, 0);
        feed_en = 0;
        repeat (5) @(negedge clk);

        // Read: header only, no data accepts, one done pulse.
        got_q.delete();
        start_q.delete();
        nd = done_q.size();
        send_cmd(1, 8'd4, 32'h0000_1000, xc);
        wait_done(dc);
        repeat (20) @(negedge clk);
        lit = '{8'h11, 8'h04, 8'h00, 8'h00, 8'h10, 8'h00};
        cmp_frame("rd_frame", lit);
        first = (start_q.size() > 0) ? start_q[0] : -1;
`ifdef DBG_CMD_UART_TX_TWO_STOP_EN
        check("rd_duration", dc - first, 1056);
`else
        check("rd_duration", dc - first, 960);
`endif
        check("rd_done_pulses", done_q.size() - nd, 1);

        // Write with data stalled for 5000 cycles after the address.
        timed = 0;
        data_arr[0] = 8'h5A;
        data_arr[1] = 8'hA5;
        feed_len = 2;
        stall = 1;
        feed_en = 1;
        got_q.delete();
        start_q.delete();
        send_cmd(0, 8'd2, 32'hCAFE_0001, xc);
        repeat (2 + 6 * BYTE_CYC) @(negedge clk);
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            #3;
            if (!bus.busy_o || !bus.txd_o || bus.wr_data_accept_o) bad++;
        end
        check("stall_hold", bad, 0);
        stall = 0;
        wait_done(dc);
        lit = '{8'h10, 8'h02, 8'hCA, 8'hFE, 8'h00, 8'h01, 8'h5A, 8'hA5};
        cmp_frame("stall_frame", lit);
        feed_en = 0;
        repeat (5) @(negedge clk);
        timed = 1;

        // Back-to-back: second descriptor waits until the cycle after done_o.
        data_arr[0] = 8'h5A;
        data_arr[1] = 8'hC3;
        feed_len = 2;
        feed_en = 1;
        got_q.delete();
        start_q.delete();
        send_cmd(1, 8'd3, 32'hDEAD_BEEF, xc);
        send_cmd(0, 8'd2, 32'h0102_0304, x2);
        d1 = (done_q.size() > 0) ? done_q[done_q.size() - 1] : -100;
        check("b2b_accept_cycle", x2, d1 + 1);
        wait_done(dc);
        lit = '{8'h11, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                8'h10, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5A, 8'hC3};
        cmp_frame("b2b_frames", lit);
        first = (start_q.size() > 6) ? start_q[6] : -1;
        check("b2b_second_duration", dc - first, 8 * BYTE_CYC);
        feed_en = 0;
        repeat (5) @(negedge clk);

        // Reset during data bit 3 of the LEN byte (LEN=0x04, so that bit is 0).
        got_q.delete();
        start_q.delete();
        send_cmd(1, 8'd4, 32'h0000_1000, xc);
        target = xc + 2 + BYTE_CYC + 4 * CPB + CPB / 2;
        while (cyc < target) @(negedge clk);
        check("len_bit3_before_reset", bus.txd_o, 0);
        rst = 1'b1;
        #1;
        check("reset_txd_immediate", bus.txd_o, 1);
        check("reset_busy_immediate", bus.busy_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        got_q.delete();
        start_q.delete();
        send_cmd(1, 8'd4, 32'h00AB_CDEF, xc);
        wait_done(dc);
        lit = '{8'h11, 8'h04, 8'h00, 8'hAB, 8'hCD, 8'hEF};
        cmp_frame("post_reset_frame", lit);
        repeat (5) @(negedge clk);

        // len=0 write with data on offer: header only, nothing consumed.
        data_arr[0] = 8'hEE;
        feed_len = 2;
        feed_en = 1;
        got_q.delete();
        start_q.delete();
        send_cmd(0, 8'd0, 32'h0000_0040, xc);
        wait_done(dc);
        lit = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h40};
        cmp_frame("len0_frame", lit);
        first = (start_q.size() > 0) ? start_q[0] : -1;
`ifdef DBG_CMD_UART_TX_TWO_STOP_EN
        check("len0_duration", dc - first, 1056);
`else
        check("len0_duration", dc - first, 960);
`endif
        feed_en = 0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dbg_cmd_uart_tx.md
Name: dbg_cmd_uart_tx

Overview:
- Host-side initiator for the UART debug bridge command protocol.
- Takes one command descriptor (read or write, length, 32-bit address) plus a write-data byte stream.
- Emits the byte frame [CMD][LEN][ADDR31:24][ADDR23:16][ADDR15:8][ADDR7:0][DATA...] as 8N1 UART serial on txd_o.
- Drives a bridge's UART_rxd in loopback system tests, and serves as an on-chip bridge master.

Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (868), clocks per serial bit, integer-truncated.
- CMD_WRITE, 8'h10, command byte for a write.
- CMD_READ, 8'h11, command byte for a read.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous reset, active-high.
- cmd_valid_i  in  1  command descriptor valid.
- cmd_accept_o  out  1  descriptor accepted this cycle (valid & accept = transfer).
- cmd_read_i  in  1  1 = read command, 0 = write command.
- cmd_len_i  in  8  byte count sent in the LEN field; for writes, also the number of data bytes that follow.
- cmd_addr_i  in  32  target address, sent MSB byte first.
- wr_data_valid_i  in  1  write data byte valid.
- wr_data_i  in  8  write data byte.
- wr_data_accept_o  out  1  data byte consumed this cycle.
- txd_o  out  1  UART serial output, idle high.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse after the last stop bit of a frame.

Behaviour:
- Reset values: txd_o=1, cmd_accept_o=0, wr_data_accept_o=0, busy_o=0, done_o=0; all counters 0; FSM in IDLE.
- Reset mid-frame aborts immediately: txd_o returns high with no partial stop bit; the partial frame is discarded.
- Command handshake:
  - cmd_accept_o = 1 only in IDLE (combinational from state).
  - On transfer, latch read flag, len and addr; go to CMD the next cycle; busy_o=1 from that cycle.
- Frame FSM: IDLE -> CMD -> LEN -> ADDR (4 bytes, counter 3..0, MSB first) -> DATA (writes with len>0 only) -> DONE -> IDLE.
  - Reads and len=0 writes go ADDR -> DONE.
  - DONE asserts done_o for one cycle, clears busy_o, and returns to IDLE.
- Byte serializer, shared by all states:
  - Loads a byte when idle and the FSM presents one.
  - Shifts: start bit (0), 8 data bits LSB first, stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
  - Bytes are back-to-back: the next start bit begins the cycle after the previous stop bit ends, whenever the next byte is available.
- DATA state:
  - wr_data_accept_o = 1 when the serializer is free and wr_data_valid_i = 1; the byte loads that cycle.
  - If wr_data_valid_i = 0, txd_o stays high (extended idle) until data arrives. No timeout, no error.
  - The remaining-byte counter decrements per accept; DATA exits after len bytes.
  - wr_data_accept_o is never asserted outside DATA.
- Reads: the response is not captured by this block; it completes at the last address-byte stop bit.
- Frame duration with no stalls: (6 + N_data) × 10 × CLKS_PER_BIT cycles, measured from the first start bit to done_o (done_o one cycle after the last stop bit).
- Simultaneous done_o and cmd_valid_i: the command is not accepted until the cycle after DONE, when the FSM is in IDLE.

Optional Feature:
- Macro: DBG_CMD_UART_TX_TWO_STOP_EN.
- Defined: every byte ends with two stop bits (11 bit periods per byte); frame duration uses 11 instead of 10.
- Undefined: one stop bit (8N1) as described above.

Test Plan:
- Write: cmd_read=0, len=8, addr=0x00001000, data 11 22 33 44 AA BB CC DD streamed always-valid -> a UART monitor decodes 10 08 00 00 10 00 11 22 33 44 AA BB CC DD; every bit 868 clocks; done_o exactly 14×10×868 cycles after the first start bit (+1).
- Read: cmd_read=1, len=4, addr=0x00001000 -> decodes 11 04 00 00 10 00; wr_data_accept_o never asserted; done_o pulses once.
- Data stall: write len=2, hold wr_data_valid_i low 5000 cycles after the address -> txd_o high throughout the stall; then bytes decode correctly; busy_o held high.
- Back-to-back: second descriptor valid during the first frame -> accepted only in the cycle after done_o; second frame decodes correctly.
- Reset mid-frame: assert rst_i during data bit 3 of the LEN byte -> txd_o=1 and busy_o=0 immediately; a fresh read afterwards decodes cleanly.
- len=0 write -> exactly 6 bytes (10 00 + address), no data accepts.
